// File: rtl/param_bcd_counter_disp_pkg.sv
// Shared constants for the parametrised BCD/hex counter with 7-segment readout:
// active-low segment glyphs (bit 0 = segment a), the blank pattern and per-digit radix limits.
package param_bcd_counter_disp_pkg;

    localparam logic [3:0] DIG_MAX_BCD = 4'd9;
    localparam logic [3:0] DIG_MAX_HEX = 4'd15;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Nibble to active-low glyph (0-9, A, b, C, d, E, F).
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = SEG_A;
            4'd11:   seg = SEG_B;
            4'd12:   seg = SEG_C;
            4'd13:   seg = SEG_D;
            4'd14:   seg = SEG_E;
            4'd15:   seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/param_bcd_counter_disp_counter_digit.sv
// One 4-bit counter digit: radix limit 9 (BCD) or 15 (hex), clear, load with BCD
// sanitising, up/down stepping when the carry-in enable is set, and an "at limit" flag
// (at the radix limit when counting up, at zero when counting down) for the carry chain.
module counter_digit
    import param_bcd_counter_disp_pkg::*;
#(
    parameter bit BCD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       cnt_en,
    input  logic       up,
    output logic [3:0] q,
    output logic       at_limit
);

    localparam logic [3:0] LIM = BCD ? DIG_MAX_BCD : DIG_MAX_HEX;

    logic [3:0] q_r;
    logic [3:0] q_next_s;
    logic [3:0] d_load_s;
    logic       at_limit_s;

    // Out-of-range BCD nibbles load as zero so the digit never holds A-F.
    always_comb begin
        d_load_s = d;
        if (BCD && (d > DIG_MAX_BCD)) begin
            d_load_s = 4'd0;
        end else begin
            d_load_s = d;
        end
    end

    // Next digit value: clear beats load beats count beats hold.
    always_comb begin
        q_next_s = q_r;
        if (clear) begin
            q_next_s = 4'd0;
        end else if (load) begin
            q_next_s = d_load_s;
        end else if (cnt_en) begin
            if (up) begin
                q_next_s = (q_r >= LIM) ? 4'd0 : (q_r + 4'd1);
            end else begin
                q_next_s = (q_r == 4'd0) ? LIM : (q_r - 4'd1);
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Digit state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 4'd0;
        end else begin
            q_r <= q_next_s;
        end
    end

    // Carry/borrow-out: this digit would roll over on the next step in the current direction.
    always_comb begin
        at_limit_s = 1'b0;
        if (up) begin
            at_limit_s = (q_r == LIM);
        end else begin
            at_limit_s = (q_r == 4'd0);
        end
    end

    assign q        = q_r;
    assign at_limit = at_limit_s;

endmodule

// File: rtl/param_bcd_counter_disp.sv
// N-digit BCD/hex up/down counter with parallel load, wrap or saturate, terminal-count
// flag and a same-cycle active-low 7-segment readout with optional leading-zero blanking.
module param_bcd_counter_disp
    import param_bcd_counter_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BCD      = 0,
    parameter int SATURATE = 0,
    parameter int BLANK_LZ = 0
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Enable,
    input  logic                  Up,
    input  logic                  Clear,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic [7*DIGITS-1:0]   HEX
);

    logic [DIGITS-1:0]   at_limit_s;
    logic [DIGITS-1:0]   carry_s;
    logic [4*DIGITS-1:0] q_s;
    logic [7*DIGITS-1:0] hex_s;
    logic                all_limit_s;
    logic                sat_hold_s;
    logic                tc_s;

    // Every digit at its limit means Q is at MAX (counting up) or at zero (counting down).
    assign all_limit_s = &at_limit_s;
    assign sat_hold_s  = (SATURATE != 0) && all_limit_s;

    // Carry chain: digit i steps when counting is enabled, not pinned by saturation,
    // and all lower digits are at their limit.
    always_comb begin
        logic acc;
        acc     = Enable & ~sat_hold_s;
        carry_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            carry_s[i] = acc;
            acc        = acc & at_limit_s[i];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        counter_digit #(
            .BCD (BCD != 0)
        ) u_digit (
            .clk      (Clock),
            .rst_n    (Resetn),
            .clear    (Clear),
            .load     (Load),
            .d        (D[4*g +: 4]),
            .cnt_en   (carry_s[g]),
            .up       (Up),
            .q        (q_s[4*g +: 4]),
            .at_limit (at_limit_s[g])
        );
    end

    // Terminal count: the next enabled step wraps or saturates; forced low while in reset.
    always_comb begin
        tc_s = 1'b0;
        if (Resetn) begin
            tc_s = Enable & all_limit_s;
        end else begin
            tc_s = 1'b0;
        end
    end

    // Segment decode with leading-zero blanking scanned from the most significant digit down.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        hex_s    = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (q_s[4*i +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && (i != 0) && zero_run) begin
                hex_s[7*i +: 7] = SEG_BLANK;
            end else begin
                hex_s[7*i +: 7] = seg_decode(q_s[4*i +: 4]);
            end
        end
    end

    assign Q   = q_s;
    assign TC  = tc_s;
    assign HEX = hex_s;

endmodule

// File: tb/tb_param_bcd_counter_disp.sv
// Bench for param_bcd_counter_disp: four differently configured instances share one
// stimulus stream and are compared every cycle against an integer-valued reference model.
module tb_param_bcd_counter_disp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        up;
    logic        clr;
    logic        ld;
    logic [15:0] d;

    logic [15:0] q_a;  logic tc_a;  logic [27:0] hex_a;
    logic [15:0] q_b;  logic tc_b;  logic [27:0] hex_b;
    logic [7:0]  q_c;  logic tc_c;  logic [13:0] hex_c;
    logic [11:0] q_d;  logic tc_d;  logic [20:0] hex_d;

    always #5 clk = ~clk;

    // A: 4-digit hex, saturating.  B: 4-digit BCD, wrapping, blanking.
    // C: 2-digit BCD, wrapping.     D: 3-digit hex, wrapping, blanking.
    param_bcd_counter_disp #(.DIGITS(4), .BCD(0), .SATURATE(1), .BLANK_LZ(0)) dut_a (
        .Clock(clk), .Resetn(rst_n), .Enable(en), .Up(up), .Clear(clr), .Load(ld),
        .D(d), .Q(q_a), .TC(tc_a), .HEX(hex_a));
    param_bcd_counter_disp #(.DIGITS(4), .BCD(1), .SATURATE(0), .BLANK_LZ(1)) dut_b (
        .Clock(clk), .Resetn(rst_n), .Enable(en), .Up(up), .Clear(clr), .Load(ld),
        .D(d), .Q(q_b), .TC(tc_b), .HEX(hex_b));
    param_bcd_counter_disp #(.DIGITS(2), .BCD(1), .SATURATE(0), .BLANK_LZ(0)) dut_c (
        .Clock(clk), .Resetn(rst_n), .Enable(en), .Up(up), .Clear(clr), .Load(ld),
        .D(d[7:0]), .Q(q_c), .TC(tc_c), .HEX(hex_c));
    param_bcd_counter_disp #(.DIGITS(3), .BCD(0), .SATURATE(0), .BLANK_LZ(1)) dut_d (
        .Clock(clk), .Resetn(rst_n), .Enable(en), .Up(up), .Clear(clr), .Load(ld),
        .D(d[11:0]), .Q(q_d), .TC(tc_d), .HEX(hex_d));

    int     cfg_dig [4] = '{4, 4, 2, 3};
    bit     cfg_bcd [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit     cfg_sat [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    bit     cfg_blk [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    longint mv [4];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
            3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
            9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
           12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
           15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic longint rad(input int k);
        return cfg_bcd[k] ? 64'd10 : 64'd16;
    endfunction

    function automatic longint pw(input int k, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * rad(k);
        return r;
    endfunction

    function automatic longint maxv(input int k);
        return pw(k, cfg_dig[k]) - 1;
    endfunction

    // Numeric value of a load word after BCD sanitising of each nibble.
    function automatic longint load_val(input logic [15:0] dv, input int k);
        longint v = 0;
        int nib;
        for (int i = 0; i < cfg_dig[k]; i++) begin
            nib = int'(dv[4*i +: 4]);
            if (cfg_bcd[k] && nib > 9) nib = 0;
            v = v + longint'(nib) * pw(k, i);
        end
        return v;
    endfunction

    function automatic logic [63:0] to_dig(input longint v, input int k);
        logic [63:0] q = '0;
        for (int i = 0; i < cfg_dig[k]; i++) q[4*i +: 4] = 4'((v / pw(k, i)) % rad(k));
        return q;
    endfunction

    function automatic logic [63:0] exp_hex(input longint v, input int k);
        logic [63:0] h = '0;
        int nib;
        for (int i = 0; i < cfg_dig[k]; i++) begin
            nib = int'((v / pw(k, i)) % rad(k));
            if (cfg_blk[k] && i > 0 && v < pw(k, i)) h[7*i +: 7] = 7'b1111111;
            else                                       h[7*i +: 7] = glyph(nib);
        end
        return h;
    endfunction

    task automatic check_all();
        logic [63:0] oq, oh;
        logic        ot, et;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       begin oq = 64'(q_a); ot = tc_a; oh = 64'(hex_a); end
                1:       begin oq = 64'(q_b); ot = tc_b; oh = 64'(hex_b); end
                2:       begin oq = 64'(q_c); ot = tc_c; oh = 64'(hex_c); end
                default: begin oq = 64'(q_d); ot = tc_d; oh = 64'(hex_d); end
            endcase
            et = rst_n && en && (up ? (mv[k] == maxv(k)) : (mv[k] == 0));
            check($sformatf("q_%0d", k),   oq,      to_dig(mv[k], k));
            check($sformatf("tc_%0d", k),  64'(ot), 64'(et));
            check($sformatf("hex_%0d", k), oh,      exp_hex(mv[k], k));
        end
    endtask

    // Reference behaviour for the coming rising edge, in plain integer arithmetic.
    task automatic model_tick();
        for (int k = 0; k < 4; k++) begin
            if (!rst_n)                  mv[k] = 0;
            else if (clr)                mv[k] = 0;
            else if (ld)                 mv[k] = load_val(d, k);
            else if (en && up)           mv[k] = (mv[k] == maxv(k)) ? (cfg_sat[k] ? maxv(k) : 0) : mv[k] + 1;
            else if (en && !up)          mv[k] = (mv[k] == 0) ? (cfg_sat[k] ? 0 : maxv(k)) : mv[k] - 1;
        end
    endtask

    task automatic cycle(input logic e, input logic u, input logic c, input logic l,
                         input logic [15:0] dv);
        @(negedge clk);
        en = e; up = u; clr = c; ld = l; d = dv;
        #1;
        check_all();
        model_tick();
    endtask

    initial begin
        bit dir;
        int r;
        logic [15:0] dv;
        rst_n = 1'b0; en = 1'b1; up = 1'b0; clr = 1'b0; ld = 1'b0; d = 16'h0000;
        for (int k = 0; k < 4; k++) mv[k] = 0;
        repeat (2) @(negedge clk);
        #1;
        check_all();
        check("rst_hex0", 64'(hex_a[6:0]), 64'(7'b1000000));
        check("rst_blank", 64'(hex_b[27:7]), 64'(21'h1FFFFF));
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of a count run.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        @(posedge clk);
        #2;
        rst_n = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) mv[k] = 0;
        check("async_q", 64'(q_a), 64'h0);
        check("async_tc", 64'(tc_a), 64'h0);
        check("async_hex0", 64'(hex_a[6:0]), 64'(7'b1000000));
        @(negedge clk);
        #1;
        check_all();
        en = 1'b0;
        rst_n = 1'b1;

        // Full 2-digit BCD sweep 00..99 and wrap.
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            if (i == 99) begin
                check("c_at_99", 64'(q_c), 64'h99);
                check("c_tc_99", 64'(tc_c), 64'h1);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("c_wrap", 64'(q_c), 64'h00);

        // Hex saturation at FFFF, then step back down.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFE);
        repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("a_sat_hold", 64'(q_a), 64'hFFFF);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("a_sat_down", 64'(q_a), 64'hFFFE);

        // BCD load sanitising, load beats enable.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h9A3C);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("b_load_bcd", 64'(q_b), 64'h9030);
        check("a_load_hex", 64'(q_a), 64'h9A3C);

        // Clear beats load and enable; then borrow from zero wraps to MAX.
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("b_clear", 64'(q_b), 64'h0);
        check("b_tc_zero", 64'(tc_b), 64'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        check("b_wrap_down", 64'(q_b), 64'h9999);
        check("d_wrap_down", 64'(q_d), 64'hFFF);

        // Leading-zero blanking on 0050.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0050);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check("b_blank_hi", 64'(hex_b[27:14]), 64'h3FFF);
        check("b_digit1", 64'(hex_b[13:7]), 64'(7'b0010010));
        check("b_digit0", 64'(hex_b[6:0]), 64'(7'b1000000));
        check("a_no_blank", 64'(hex_a[27:21]), 64'(7'b1000000));

        // Randomised run with a sticky direction so the limits get reached.
        dir = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            r  = int'($urandom_range(0, 63));
            if ($urandom_range(0, 39) == 0) dir = ~dir;
            dv = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       dv = 16'h9998 + 16'($urandom_range(0, 1));
                1:       dv = 16'hFFFD + 16'($urandom_range(0, 2));
                2:       dv = 16'h0001;
                default: dv = dv;
            endcase
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? ~dir : dir,
                  r == 0, r < 5, dv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
